fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-entry fetch path with a decoupled fetch queue. It drives a synchronous instruction RAM with one-cycle read latency, tags every returned word with its PC, and buffers it in a FIFO of configurable depth. Decode consumes instructions through a valid/ready handshake, and a single redirect port (branch/jump target resolved downstream) flushes the stage. It sits between the PC source logic and the ID stage.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decode handshake, redirect port and instruction-RAM port.
// The master modport belongs to fetch_unit; the slave modport is the surrounding pipeline/RAM.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IMEM_AW    = 10
) ();
  logic                  W_redirect_valid;
  logic [ADDR_WIDTH-1:0] W_redirect_pc;
  logic                  W_id_ready;
  logic                  W_instr_valid;
  logic [31:0]           W_instr;
  logic [ADDR_WIDTH-1:0] W_IF_PC;
  logic                  W_imem_en;
  logic [IMEM_AW-1:0]    W_imem_addr;
  logic [31:0]           W_imem_rdata;

  modport master (
    input  W_redirect_valid, W_redirect_pc, W_id_ready, W_imem_rdata,
    output W_instr_valid, W_instr, W_IF_PC, W_imem_en, W_imem_addr
  );

  modport slave (
    output W_redirect_valid, W_redirect_pc, W_id_ready, W_imem_rdata,
    input  W_instr_valid, W_instr, W_IF_PC, W_imem_en, W_imem_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: issues RAM reads under a credit limit, tags each
// returned word with its PC and queues it for decode; a redirect flushes and restarts.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FQ_DEPTH   = 4,
  parameter int unsigned           IMEM_AW    = 10
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  typedef logic [ADDR_WIDTH-1:0] pc_t;

  pc_t           fetch_pc_q, fetch_pc_d;
  pc_t           inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   instr_mem [FQ_DEPTH];
  pc_t           pc_mem    [FQ_DEPTH];

  pc_t           issue_pc;
  logic          pop, push, issue, credit_ok;
  logic [OW-1:0] occupancy;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^bus.W_redirect_pc[1:0];

  // Occupancy counts queued words plus the read returning this cycle, minus the word leaving.
  always_comb begin
    pop       = (count_q != '0) && bus.W_id_ready;
    push      = inflight_q && !bus.W_redirect_valid;
    issue_pc  = bus.W_redirect_valid ? {bus.W_redirect_pc[ADDR_WIDTH-1:2], 2'b00} : fetch_pc_q;
    occupancy = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);
    credit_ok = occupancy < OW'(FQ_DEPTH);
    issue     = rst && (bus.W_redirect_valid || credit_ok);
  end

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    count_d       = count_q + CW'(push) - CW'(pop);
    if (issue) begin
      fetch_pc_d    = issue_pc + pc_t'(4);
      inflight_d    = 1'b1;
      inflight_pc_d = issue_pc;
    end
    if (bus.W_redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.W_imem_rdata;
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign bus.W_instr_valid = (count_q != '0);
  assign bus.W_instr       = bus.W_instr_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.W_IF_PC       = bus.W_instr_valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.W_imem_en     = issue;
  assign bus.W_imem_addr   = issue_pc[IMEM_AW+1:2];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based stream model checked every cycle,
// directed scenarios with literal expectations, then randomized ready/redirect traffic.
module tb_fetch_unit;
  localparam int unsigned AW    = 32;
  localparam int unsigned IAW   = 10;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .IMEM_AW(IAW)) bus ();

  fetch_unit #(
    .ADDR_WIDTH(AW), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH), .IMEM_AW(IAW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [IAW-1:0] a);
    return 32'hA5A5_0000 ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  function automatic logic [31:0] word_at_pc(input logic [31:0] pc);
    return word_of(pc[IAW+1:2]);
  endfunction

  // Synchronous instruction RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.W_imem_en) bus.W_imem_rdata <= word_of(bus.W_imem_addr);
  end

  // Stream model: every word issued since the last redirect/reset, oldest first,
  // with the cycle it was issued. A word is presentable two cycles after issue.
  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] next_pc = 32'h0;
  int          mc = 0;

  always @(negedge clk) begin
    logic        exp_valid, exp_pop, exp_en;
    logic [31:0] tgt;
    if (!rst) begin
      check("rst_valid", bus.W_instr_valid, 1'b0);
      check("rst_en",    bus.W_imem_en,     1'b0);
      check("rst_instr", bus.W_instr,       32'h0);
      check("rst_pc",    bus.W_IF_PC,       32'h0);
      q.delete();
      next_pc = 32'h0;
    end else begin
      exp_valid = (q.size() > 0) && (q[0].cyc <= mc - 2);
      check("m_valid", bus.W_instr_valid, exp_valid);
      if (exp_valid) begin
        check("m_pc",    bus.W_IF_PC, q[0].pc);
        check("m_instr", bus.W_instr, word_at_pc(q[0].pc));
      end
      exp_pop = exp_valid && bus.W_id_ready;
      if (exp_pop) void'(q.pop_front());
      if (bus.W_redirect_valid) begin
        tgt = {bus.W_redirect_pc[31:2], 2'b00};
        q.delete();
        exp_en  = 1'b1;
        next_pc = tgt;
      end else begin
        exp_en = (q.size() < DEPTH);
      end
      check("m_en", bus.W_imem_en, exp_en);
      if (exp_en) begin
        check("m_addr", bus.W_imem_addr, next_pc[IAW+1:2]);
        q.push_back('{pc: next_pc, cyc: mc});
        next_pc = next_pc + 32'd4;
      end
    end
    mc++;
  end

  // One cycle of stimulus: inputs change just after the rising edge,
  // then return just after the falling edge for literal checks.
  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk); #1;
    bus.W_redirect_valid = rv;
    bus.W_redirect_pc    = rpc;
    bus.W_id_ready       = rdy;
    @(negedge clk); #1;
  endtask

  initial begin
    rst                  = 1'b0;
    bus.W_redirect_valid = 1'b0;
    bus.W_redirect_pc    = '0;
    bus.W_id_ready       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.W_id_ready = 1'b1;
    @(negedge clk); #1;
    check("c0_en",   bus.W_imem_en,   1'b1);
    check("c0_addr", bus.W_imem_addr, 10'h000);
    drive(1'b0, 32'h0, 1'b1);
    check("c1_addr", bus.W_imem_addr, 10'h001);
    check("c1_valid", bus.W_instr_valid, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("c2_valid", bus.W_instr_valid, 1'b1);
    check("c2_pc",    bus.W_IF_PC, 32'h0);
    check("c2_instr", bus.W_instr, 32'hA5A5_0000);
    drive(1'b0, 32'h0, 1'b1);
    check("c3_pc",    bus.W_IF_PC, 32'h4);

    // Back-pressure: queue fills, fetch stalls, then drains contiguously.
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b0);
    check("bp_en",    bus.W_imem_en,     1'b0);
    check("bp_valid", bus.W_instr_valid, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 32'h0, 1'b1);

    // Redirect with a full queue; low target bits are dropped.
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h0000_0103, 1'b0);
    check("rd_en",   bus.W_imem_en,   1'b1);
    check("rd_addr", bus.W_imem_addr, 10'h040);
    drive(1'b0, 32'h0, 1'b0);
    check("rd_t1_valid", bus.W_instr_valid, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("rd_t2_pc", bus.W_IF_PC, 32'h100);
    drive(1'b0, 32'h0, 1'b1);
    check("rd_t3_pc", bus.W_IF_PC, 32'h104);

    // Redirect coinciding with a pop of head 0x20.
    drive(1'b1, 32'h20, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h200, 1'b1);
    check("rp_head_pc", bus.W_IF_PC, 32'h20);
    drive(1'b0, 32'h0, 1'b1);
    check("rp_t1_valid", bus.W_instr_valid, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("rp_t2_pc", bus.W_IF_PC, 32'h200);

    // Back-to-back redirects: only the second target survives.
    drive(1'b1, 32'h300, 1'b1);
    drive(1'b1, 32'h400, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("bb_t1_valid", bus.W_instr_valid, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("bb_t2_pc", bus.W_IF_PC, 32'h400);

    // PC wrap at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("wr_pc_top", bus.W_IF_PC, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1);
    check("wr_pc_zero", bus.W_IF_PC, 32'h0);

    // Randomized ready and occasional redirects.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-stream, then restart at RESET_PC.
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ar_valid", bus.W_instr_valid, 1'b0);
    check("ar_en",    bus.W_imem_en,     1'b0);
    check("ar_pc",    bus.W_IF_PC,       32'h0);
    check("ar_instr", bus.W_instr,       32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("ar_c0_en",   bus.W_imem_en,   1'b1);
    check("ar_c0_addr", bus.W_imem_addr, 10'h000);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("ar_c2_pc",    bus.W_IF_PC, 32'h0);
    check("ar_c2_valid", bus.W_instr_valid, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("ar_c3_pc",    bus.W_IF_PC, 32'h4);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
